// File: rtl/tiled_psum_accumulator_pkg.sv
// Shared types and helpers for the tiled partial-sum accumulator.
package kan_tiling_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FINAL = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Working width for saturating arithmetic; every target width must be below this.
    localparam int unsigned SAT_W = 64;

    localparam int unsigned DEF_MAX_TILES = 16;
    localparam int unsigned DEF_ACC_DEPTH = 64;

    // Width of a counter/config field able to hold the value n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Clamp x to the signed range of a w-bit value.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                    input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
        lo = ~hi;
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/tiled_psum_accumulator_lane_ram.sv
// Per-lane accumulator storage: async read, sync write on a shared address.
module psum_lane_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 24,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/tiled_psum_accumulator.sv
// Sums cfg_tiles passes of per-lane psums in on-chip RAM and streams saturated
// final sums on the last pass; all lanes move in lockstep.
module tiled_psum_accumulator
    import kan_tiling_pkg::*;
#(
    parameter int unsigned BATCH_SIZE    = 1,
    parameter int unsigned RSLT_CHANNELS = 1,
    parameter int unsigned RSLT_WIDTH    = 16,
    parameter int unsigned ACC_WIDTH     = RSLT_WIDTH + 8,
    parameter int unsigned ACC_DEPTH     = DEF_ACC_DEPTH,
    parameter int unsigned MAX_TILES     = DEF_MAX_TILES,
    localparam int unsigned LANES  = RSLT_CHANNELS * BATCH_SIZE,
    localparam int unsigned TILE_W = cnt_w(MAX_TILES),
    localparam int unsigned LEN_W  = cnt_w(ACC_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [TILE_W-1:0]           cfg_tiles,
    input  logic [LEN_W-1:0]            cfg_len,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [LANES*RSLT_WIDTH-1:0] s_axis_psum_tdata,
    input  logic [LANES-1:0]            s_axis_psum_tvalid,
    input  logic [LANES-1:0]            s_axis_psum_tlast,
    output logic [LANES-1:0]            s_axis_psum_tready,
    output logic [LANES*RSLT_WIDTH-1:0] m_axis_data_tdata,
    output logic [LANES-1:0]            m_axis_data_tvalid,
    output logic [LANES-1:0]            m_axis_data_tlast,
    input  logic [LANES-1:0]            m_axis_data_tready,
    output logic                        busy,
    output logic                        err_unaligned_pass
);

    localparam int unsigned AW = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

    state_t state;
    state_t state_nx;

    logic [TILE_W-1:0]           tiles_q;
    logic [TILE_W-1:0]           tile_q;
    logic [AW-1:0]               last_q;
    logic [AW-1:0]               addr_q;
    logic                        out_valid_q;
    logic                        out_last_q;
    logic [LANES*RSLT_WIDTH-1:0] out_data_q;
    logic                        err_q;

    logic [TILE_W-1:0]           tiles_in;
    logic [AW-1:0]               last_in;
    logic                        all_valid;
    logic                        all_ready;
    logic                        out_fire;
    logic                        out_free;
    logic                        accept;
    logic                        addr_end;
    logic                        tile_end;
    logic                        first_pass;
    logic                        wr_en;
    logic [LANES*RSLT_WIDTH-1:0] fin_data;

    // Config decode: zero or out-of-range values fall back to the nearest legal setting.
    always_comb begin
        tiles_in = cfg_tiles;
        if (cfg_tiles == '0) begin
            tiles_in = TILE_W'(1);
        end else if (cfg_tiles > TILE_W'(MAX_TILES)) begin
            tiles_in = TILE_W'(MAX_TILES);
        end
        last_in = AW'(cfg_len - LEN_W'(1));
        if (cfg_len == '0 || cfg_len > LEN_W'(ACC_DEPTH)) begin
            last_in = AW'(ACC_DEPTH - 1);
        end
    end

    assign all_valid  = &s_axis_psum_tvalid;
    assign all_ready  = &m_axis_data_tready;
    assign out_fire   = out_valid_q & all_ready;
    assign out_free   = ~out_valid_q | all_ready;
    assign accept     = all_valid & ((state == ST_ACCUM) | ((state == ST_FINAL) & out_free));
    assign addr_end   = (addr_q == last_q);
    assign tile_end   = (tile_q == TILE_W'(tiles_q - TILE_W'(2)));
    assign first_pass = (tile_q == '0);
    assign wr_en      = accept & (state == ST_ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    state_nx = (tiles_in > TILE_W'(1)) ? ST_ACCUM : ST_FINAL;
                end
            end
            ST_ACCUM: begin
                if (accept && addr_end && tile_end) begin
                    state_nx = ST_FINAL;
                end
            end
            ST_FINAL: begin
                if (accept && addr_end) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Counters, tlast checker and one-deep output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tiles_q     <= TILE_W'(1);
            tile_q      <= '0;
            last_q      <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if ((state == ST_IDLE) && cfg_valid) begin
                tiles_q <= tiles_in;
                last_q  <= last_in;
                addr_q  <= '0;
                tile_q  <= '0;
                err_q   <= 1'b0;
            end
            if (accept) begin
                if (s_axis_psum_tlast != {LANES{addr_end}}) begin
                    err_q <= 1'b1;
                end
                addr_q <= addr_end ? '0 : AW'(addr_q + AW'(1));
                if (addr_end && (state == ST_ACCUM)) begin
                    tile_q <= TILE_W'(tile_q + TILE_W'(1));
                end
            end
            if (accept && (state == ST_FINAL)) begin
                out_valid_q <= 1'b1;
                out_last_q  <= addr_end;
                out_data_q  <= fin_data;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        logic signed [RSLT_WIDTH-1:0] psum;
        logic signed [ACC_WIDTH-1:0]  acc_rd;
        logic signed [ACC_WIDTH-1:0]  acc_wr;
        logic signed [SAT_W-1:0]      sum;

        assign psum   = s_axis_psum_tdata[g*RSLT_WIDTH +: RSLT_WIDTH];
        // The first pass ignores stale RAM contents, so no clear is ever needed.
        assign sum    = SAT_W'(psum) + (first_pass ? SAT_W'(0) : SAT_W'(acc_rd));
        assign acc_wr = ACC_WIDTH'(sat(sum, ACC_WIDTH));
        assign fin_data[g*RSLT_WIDTH +: RSLT_WIDTH] = RSLT_WIDTH'(sat(sum, RSLT_WIDTH));

        psum_lane_ram #(
            .DEPTH (ACC_DEPTH),
            .WIDTH (ACC_WIDTH),
            .AW    (AW)
        ) u_ram (
            .clk     (clk),
            .wr_en   (wr_en),
            .addr    (addr_q),
            .wr_data (acc_wr),
            .rd_data (acc_rd)
        );
    end

    assign cfg_ready          = (state == ST_IDLE);
    assign busy               = (state != ST_IDLE);
    assign err_unaligned_pass = err_q;
    assign s_axis_psum_tready = {LANES{accept}};
    assign m_axis_data_tvalid = {LANES{out_valid_q}};
    assign m_axis_data_tlast  = {LANES{out_last_q}};
    assign m_axis_data_tdata  = out_data_q;

endmodule

// File: tb/tb_tiled_psum_accumulator.sv
// Directed bench for tiled_psum_accumulator with two lanes, 16-bit results, 24-bit accumulators.
module tb_tiled_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  cfg_tiles;
    logic [6:0]  cfg_len;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] s_tdata;
    logic [1:0]  s_tvalid;
    logic [1:0]  s_tlast;
    logic [1:0]  s_tready;
    logic [31:0] m_tdata;
    logic [1:0]  m_tvalid;
    logic [1:0]  m_tlast;
    logic [1:0]  m_tready;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    tiled_psum_accumulator #(
        .BATCH_SIZE    (1),
        .RSLT_CHANNELS (2),
        .RSLT_WIDTH    (16),
        .ACC_WIDTH     (24),
        .ACC_DEPTH     (64),
        .MAX_TILES     (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_tiles          (cfg_tiles),
        .cfg_len            (cfg_len),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .s_axis_psum_tdata  (s_tdata),
        .s_axis_psum_tvalid (s_tvalid),
        .s_axis_psum_tlast  (s_tlast),
        .s_axis_psum_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tlast  (m_tlast),
        .m_axis_data_tready (m_tready),
        .busy               (busy),
        .err_unaligned_pass (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [4:0] t, input logic [6:0] l);
        cfg_tiles = t;
        cfg_len   = l;
        cfg_valid = 1'b1;
        #1;
        chk("cfg_ready_idle", 64'(cfg_ready), 64'(1'b1));
        tick();
        cfg_valid = 1'b0;
    endtask

    // One full-lane beat, expected to be accepted in this cycle.
    task automatic send(input logic [15:0] d0, input logic [15:0] d1, input logic [1:0] lst);
        s_tdata  = {d1, d0};
        s_tvalid = 2'b11;
        s_tlast  = lst;
        #1;
        chk("s_tready_beat", 64'(s_tready), 64'(2'b11));
        tick();
        s_tvalid = 2'b00;
        s_tlast  = 2'b00;
    endtask

    initial begin
        rst       = 1'b1;
        cfg_tiles = '0;
        cfg_len   = '0;
        cfg_valid = 1'b0;
        s_tdata   = '0;
        s_tvalid  = 2'b00;
        s_tlast   = 2'b00;
        m_tready  = 2'b11;
        tick();
        tick();

        // Reset values, with inputs valid to show IDLE never consumes.
        s_tvalid = 2'b11;
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(2'b00));
        chk("rst_m_tlast", 64'(m_tlast), 64'(2'b00));
        chk("rst_m_tdata", 64'(m_tdata), 64'(32'h0));
        chk("rst_s_tready", 64'(s_tready), 64'(2'b00));
        chk("rst_cfg_ready", 64'(cfg_ready), 64'(1'b1));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_err", 64'(err), 64'(1'b0));
        s_tvalid = 2'b00;
        rst      = 1'b0;
        tick();

        // Single pass, L=4: pass-through with one-cycle latency.
        cfg(5'd1, 7'd4);
        chk("t1_busy", 64'(busy), 64'(1'b1));
        chk("t1_cfg_ready", 64'(cfg_ready), 64'(1'b0));
        chk("t1_no_early_out", 64'(m_tvalid), 64'(2'b00));
        for (int i = 1; i <= 4; i++) begin
            send(16'(i), 16'(10 * i), (i == 4) ? 2'b11 : 2'b00);
            chk("t1_m_tvalid", 64'(m_tvalid), 64'(2'b11));
            chk("t1_m_tdata", 64'(m_tdata), 64'({16'(10 * i), 16'(i)}));
            chk("t1_m_tlast", 64'(m_tlast), 64'((i == 4) ? 2'b11 : 2'b00));
        end
        tick();
        chk("t1_drained", 64'(m_tvalid), 64'(2'b00));
        chk("t1_idle_ready", 64'(cfg_ready), 64'(1'b1));
        chk("t1_idle_busy", 64'(busy), 64'(1'b0));
        chk("t1_err", 64'(err), 64'(1'b0));

        // Three passes, L=2; a cfg offered mid-run is ignored.
        cfg(5'd3, 7'd2);
        send(16'd10, 16'h03E8, 2'b00);
        chk("t2_no_out_p0", 64'(m_tvalid), 64'(2'b00));
        cfg_tiles = 5'd1;
        cfg_len   = 7'd1;
        cfg_valid = 1'b1;
        #1;
        chk("t2_cfg_ignored", 64'(cfg_ready), 64'(1'b0));
        tick();
        cfg_valid = 1'b0;
        send(16'd20, 16'hFC18, 2'b11);
        send(16'd1, 16'd1, 2'b00);
        send(16'd2, 16'd1, 2'b11);
        chk("t2_no_out_p1", 64'(m_tvalid), 64'(2'b00));
        chk("t2_busy", 64'(busy), 64'(1'b1));
        send(16'd100, 16'hF830, 2'b00);
        chk("t2_out0_valid", 64'(m_tvalid), 64'(2'b11));
        chk("t2_out0_data", 64'(m_tdata), 64'({16'hFC19, 16'd111}));
        chk("t2_out0_last", 64'(m_tlast), 64'(2'b00));
        send(16'd200, 16'h0BB8, 2'b11);
        chk("t2_out1_data", 64'(m_tdata), 64'({16'h07D1, 16'd222}));
        chk("t2_out1_last", 64'(m_tlast), 64'(2'b11));
        tick();
        chk("t2_idle", 64'(cfg_ready), 64'(1'b1));
        chk("t2_err", 64'(err), 64'(1'b0));

        // Saturation of the final sum in both directions.
        cfg(5'd2, 7'd1);
        send(16'h7000, 16'h9000, 2'b11);
        chk("t3_no_out_p0", 64'(m_tvalid), 64'(2'b00));
        send(16'h7000, 16'h9000, 2'b11);
        chk("t3_sat_data", 64'(m_tdata), 64'({16'h8000, 16'h7FFF}));
        chk("t3_sat_last", 64'(m_tlast), 64'(2'b11));
        tick();
        chk("t3_idle", 64'(cfg_ready), 64'(1'b1));

        // Misaligned tlast: flag is sticky, sums still emitted.
        cfg(5'd2, 7'd3);
        send(16'd1, 16'd2, 2'b00);
        send(16'd2, 16'd4, 2'b11);
        chk("t4_err_set", 64'(err), 64'(1'b1));
        send(16'd3, 16'd6, 2'b00);
        send(16'd4, 16'd8, 2'b00);
        chk("t4_out0", 64'(m_tdata), 64'({16'd10, 16'd5}));
        send(16'd5, 16'd10, 2'b00);
        chk("t4_out1", 64'(m_tdata), 64'({16'd14, 16'd7}));
        chk("t4_out1_last", 64'(m_tlast), 64'(2'b00));
        send(16'd6, 16'd12, 2'b11);
        chk("t4_out2", 64'(m_tdata), 64'({16'd18, 16'd9}));
        chk("t4_out2_last", 64'(m_tlast), 64'(2'b11));
        tick();
        chk("t4_idle", 64'(cfg_ready), 64'(1'b1));
        chk("t4_err_sticky", 64'(err), 64'(1'b1));

        // Backpressure and lane skew; cfg_tiles=0 means a single pass.
        cfg(5'd0, 7'd3);
        chk("t5_err_cleared", 64'(err), 64'(1'b0));
        send(16'd7, 16'd8, 2'b00);
        chk("t5_out0", 64'(m_tdata), 64'({16'd8, 16'd7}));
        m_tready = 2'b01;
        s_tdata  = {16'h0011, 16'h0009};
        s_tvalid = 2'b11;
        s_tlast  = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall_tready", 64'(s_tready), 64'(2'b00));
            tick();
            chk("t5_hold_valid", 64'(m_tvalid), 64'(2'b11));
            chk("t5_hold_data", 64'(m_tdata), 64'({16'd8, 16'd7}));
        end
        m_tready = 2'b11;
        #1;
        chk("t5_release_tready", 64'(s_tready), 64'(2'b11));
        tick();
        chk("t5_out1", 64'(m_tdata), 64'({16'h0011, 16'h0009}));
        s_tdata  = {16'h0022, 16'h0021};
        s_tvalid = 2'b01;
        s_tlast  = 2'b11;
        #1;
        chk("t5_skew_tready", 64'(s_tready), 64'(2'b00));
        tick();
        chk("t5_skew_no_out", 64'(m_tvalid), 64'(2'b00));
        tick();
        chk("t5_skew_busy", 64'(busy), 64'(1'b1));
        chk("t5_skew_no_out2", 64'(m_tvalid), 64'(2'b00));
        s_tvalid = 2'b11;
        #1;
        chk("t5_both_tready", 64'(s_tready), 64'(2'b11));
        tick();
        s_tvalid = 2'b00;
        s_tlast  = 2'b00;
        chk("t5_out2", 64'(m_tdata), 64'({16'h0022, 16'h0021}));
        chk("t5_out2_last", 64'(m_tlast), 64'(2'b11));
        tick();
        chk("t5_idle", 64'(cfg_ready), 64'(1'b1));
        chk("t5_err", 64'(err), 64'(1'b0));

        // Reset in the middle of tile 1, then a fresh run must not see old sums.
        cfg(5'd3, 7'd2);
        send(16'd100, 16'd100, 2'b00);
        send(16'd100, 16'd100, 2'b11);
        send(16'd50, 16'd50, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_busy", 64'(busy), 64'(1'b0));
        chk("t6_rst_ready", 64'(cfg_ready), 64'(1'b1));
        chk("t6_rst_mvalid", 64'(m_tvalid), 64'(2'b00));
        tick();
        chk("t6_rst_quiet", 64'(m_tvalid), 64'(2'b00));
        cfg(5'd2, 7'd2);
        send(16'd5, 16'd5, 2'b00);
        send(16'd5, 16'd5, 2'b11);
        send(16'd1, 16'd1, 2'b00);
        chk("t6_out0", 64'(m_tdata), 64'({16'd6, 16'd6}));
        send(16'd1, 16'd1, 2'b11);
        chk("t6_out1", 64'(m_tdata), 64'({16'd6, 16'd6}));
        chk("t6_out1_last", 64'(m_tlast), 64'(2'b11));
        tick();
        chk("t6_idle", 64'(cfg_ready), 64'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tiled_psum_accumulator.md
# tiled_psum_accumulator

Multi-pass partial-sum accumulator for KAN layers with more input features than `DATA_CHANNELS`. It sits between the linear processing array output and the output AXI-Stream. It sums `cfg_tiles` consecutive passes of per-lane partial results in on-chip storage and emits the saturated final sums on the last pass. All `RSLT_CHANNELS*BATCH_SIZE` lanes advance in lockstep.

## Interface
- `BATCH_SIZE`, 1, batches per run
- `RSLT_CHANNELS`, 1, result channels per batch; LANES = RSLT_CHANNELS*BATCH_SIZE
- `RSLT_WIDTH`, 16, signed psum and output width; input and output share fractional format, so no shift is applied
- `ACC_WIDTH`, RSLT_WIDTH+8, signed accumulator width
- `ACC_DEPTH`, 64, words per lane per pass (max `cfg_len`)
- `MAX_TILES`, 16, maximum passes per output
- `clk` in 1, sole clock
- `rst` in 1, synchronous, active-high
- `cfg_tiles` in clog2(MAX_TILES+1), passes per output; 0 is treated as 1
- `cfg_len` in clog2(ACC_DEPTH+1), words per lane per pass; 0 is treated as ACC_DEPTH
- `cfg_valid` in 1 / `cfg_ready` out 1, configuration handshake
- `s_axis_psum_tdata` in LANES*RSLT_WIDTH; `_tvalid`, `_tlast` in LANES; `_tready` out LANES
- `m_axis_data_tdata` out LANES*RSLT_WIDTH; `_tvalid`, `_tlast` out LANES; `_tready` in LANES
- `busy` out 1, high whenever the block is not IDLE
- `err_unaligned_pass` out 1, sticky error flag

## Operation
- States: IDLE, ACCUM, FINAL, DRAIN.
- IDLE
  - `cfg_ready`=1.
  - On `cfg_valid`, latch T and L, clear counters and the error flag.
  - Go to ACCUM if T>1, else FINAL.
- Beat acceptance
  - A beat is accepted only when all LANES tvalid are high and the state permits.
  - All tready bits are identical; a partial-lane valid is never consumed.
- Counters
  - `addr` runs 0..L-1 and wraps to 0; `tile` runs 0..T-1.
  - On a beat with `addr`=L-1, every lane's tlast must be 1.
  - On any other beat, every tlast must be 0.
  - Any violation sets `err_unaligned_pass`, which stays set until `rst` or the next cfg handshake. Processing continues on the counter, not on tlast.
- ACCUM
  - Tile 0 writes the sign-extended psum to `acc[lane][addr]`.
  - Tiles 1..T-2 write `sat_ACC(acc + psum)`.
  - Read is asynchronous (LUTRAM); read-modify-write completes in the accept cycle.
  - Wrap at tile T-2 goes to FINAL.
- FINAL (last pass)
  - Output = `sat_RSLT(acc + psum)`; when T=1, output = `sat_RSLT(psum)`.
  - The output goes to a one-deep output register; no write-back.
  - `m_tlast` = 1 on `addr`=L-1.
  - Input is accepted when the output register is empty or all `m_tready` are high.
  - After the L-1 beat, go to DRAIN.
- DRAIN: when the last output is accepted (all `m_tready`), go to IDLE.
- Saturation: clamp to the signed range of the target width; never wrap.

## Timing
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `s_tready`=0, `cfg_ready`=1, `busy`=0, `err_unaligned_pass`=0, state IDLE.
- ACCUM throughput is 1 beat/cycle; `s_tready` = all-valid qualifier only, no backpressure.
- FINAL latency is 1 cycle (accepted beat at n → `m_tvalid` at n+1).
- FINAL throughput is 1 beat/cycle with continuous `m_tready`.
- Output stall: held data stays stable; `s_tready` stays 0 until the output drains.
- `m_tvalid` lanes are identical. Output is accepted only when all `m_tready` are high.
- Reset mid-operation: accumulators are logically discarded (tile 0 overwrites them); no further output is produced; the block returns to IDLE next cycle.
- `cfg_valid` outside IDLE is ignored.

## Structure
- Package `kan_tiling_pkg`: state enum, `sat` function (width-parametrised via macro/constant), clog2-derived counter widths.
- Sub-module `psum_lane_ram`: one per lane, ACC_DEPTH×ACC_WIDTH, async read, sync write.
- Top: FSM, `addr`/`tile` counters, tlast checker, output register.

## Test plan
All scenarios use LANES=2, RSLT_WIDTH=16, ACC_WIDTH=24.
- T=1, L=4, psums 1,2,3,4 per lane → outputs 1,2,3,4, tlast only on 4th, 1-cycle latency, then IDLE with `cfg_ready`=1.
- T=3, L=2, lane0 psums {10,20},{1,2},{100,200} → outputs 111,222; tlast on 222; no output during the first two passes.
- Saturation: T=2, L=1, psums 0x7000 then 0x7000 → output 0x7FFF; psums 0x9000+0x9000 → output 0x8000.
- Misaligned tlast: T=2, L=3, tlast asserted on beat 2 → `err_unaligned_pass`=1 and stays high; sums still emitted after 6 beats; next cfg clears it.
- Backpressure and skew: in FINAL, `m_tready` lane1 low for 3 cycles → `s_tready`=0 and output held stable. Lane1 tvalid delayed 2 cycles → no beat consumed until both lanes are valid.
- Reset during ACCUM tile 1, then reconfigure with T=2, L=2, psums {5,5},{1,1} → outputs 6,6, no stale data.
